// File: rtl/dct2d_rowcol_sched.sv
// 8x8 2-D DCT sequencer: rows go through one shared 8-point DCT into a transpose
// buffer, then buffer columns go back through the same DCT and are streamed out.

// 8-point orthonormal DCT-II. Coefficients are scaled by 2^12. Results are floored
// (arithmetic shift) and wrap to N bits.
module dct1d #(
  parameter int N = 16
) (
  input  logic [8*N-1:0] x,
  output logic [8*N-1:0] y
);
  localparam int AW = N + 16;

  // Returns round(2048*cos(m*pi/16)) for m = 1..7.
  function automatic int cmag(input int m);
    case (m)
      1:       cmag = 2009;
      2:       cmag = 1892;
      3:       cmag = 1703;
      4:       cmag = 1448;
      5:       cmag = 1138;
      6:       cmag = 784;
      7:       cmag = 400;
      default: cmag = 0;
    endcase
  endfunction

  // Folds the cosine angle (2n+1)*k*pi/16 into the first quadrant.
  function automatic int coef(input int k, input int n);
    int m;
    if (k == 0) return 1448;
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    if (m > 8) return -cmag(16 - m);
    return cmag(m);
  endfunction

  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic signed [AW-1:0] acc;
    always_comb begin
      acc = '0;
      for (int n = 0; n < 8; n++)
        acc = acc + AW'(signed'(x[(8-n)*N-1 -: N])) * AW'(coef(k, n));
    end
    assign y[(8-k)*N-1 -: N] = N'(acc >>> 12);
  end
endmodule

module dct2d_rowcol_sched #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*N-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*N-1:0] out_col,
  output logic [2:0]     out_idx,
  output logic           out_last,
  output logic           busy
);
  typedef enum logic {S_ROW, S_COL} state_t;

  state_t         state, state_nx;
  logic [2:0]     row_cnt, row_cnt_nx;
  logic [2:0]     col_cnt, col_cnt_nx;
  logic [N-1:0]   mem [8][8];
  logic [8*N-1:0] d_in, d_out;
  logic           row_fire;

  // Shared transform input: the incoming row, or buffer column col_cnt.
  always_comb begin
    d_in = in_row;
    if (state == S_COL)
      for (int r = 0; r < 8; r++) d_in[(8-r)*N-1 -: N] = mem[r][col_cnt];
  end

  dct1d #(.N(N)) u_dct (.x(d_in), .y(d_out));

  always_comb begin
    state_nx   = state;
    row_cnt_nx = row_cnt;
    col_cnt_nx = col_cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_ROW: begin
        in_ready = 1'b1;
        if (in_valid) begin
          row_cnt_nx = row_cnt + 3'd1;
          if (row_cnt == 3'd7) begin
            state_nx   = S_COL;
            col_cnt_nx = 3'd0;
          end
        end
      end
      S_COL: begin
        out_valid = 1'b1;
        if (out_ready) begin
          col_cnt_nx = col_cnt + 3'd1;
          if (col_cnt == 3'd7) state_nx = S_ROW;
        end
      end
      default: state_nx = S_ROW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_ROW;
      row_cnt <= 3'd0;
      col_cnt <= 3'd0;
    end else begin
      state   <= state_nx;
      row_cnt <= row_cnt_nx;
      col_cnt <= col_cnt_nx;
    end
  end

  assign row_fire = in_valid && in_ready && !reset;

  // Buffer holds no reset; row_cnt restarting at 0 guarantees every entry is
  // rewritten before a column pass can read it.
  always_ff @(posedge clk) begin
    if (row_fire)
      for (int k = 0; k < 8; k++) mem[row_cnt][k] <= d_out[(8-k)*N-1 -: N];
  end

  assign out_col  = d_out;
  assign out_idx  = col_cnt;
  assign out_last = out_valid && (col_cnt == 3'd7);
  assign busy     = (state == S_COL) || (row_cnt != 3'd0);
endmodule

// File: tb/tb_dct2d_rowcol_sched.sv
// Bench for dct2d_rowcol_sched: matrix-level DCT model plus per-cycle handshake model.
module tb_dct2d_rowcol_sched;
  localparam int N = 16;
  localparam real PI = 3.14159265358979323846;

  typedef int vec_t [8];

  logic           clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [8*N-1:0] in_row = '0;
  logic           in_ready, out_valid, out_last, busy;
  logic [8*N-1:0] out_col;
  logic [2:0]     out_idx;

  dct2d_rowcol_sched #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Coefficient table derived from the orthonormal DCT-II definition.
  int cf [8][8];

  function automatic int wrapn(input longint v);
    longint m;
    m = v & ((longint'(1) << N) - 1);
    if (m[N-1]) m = m - (longint'(1) << N);
    return int'(m);
  endfunction

  function automatic vec_t dct8(input vec_t x);
    vec_t y;
    for (int k = 0; k < 8; k++) begin
      longint s = 0;
      for (int n = 0; n < 8; n++) s += longint'(x[n]) * longint'(cf[k][n]);
      y[k] = wrapn(s >>> 12);
    end
    return y;
  endfunction

  function automatic int lane(input logic [8*N-1:0] v, input int i);
    logic signed [N-1:0] s;
    s = v[(7-i)*N +: N];
    return int'(s);
  endfunction

  function automatic logic [8*N-1:0] rep(input int v);
    logic [8*N-1:0] r;
    for (int i = 0; i < 8; i++) r[i*N +: N] = N'(v);
    return r;
  endfunction

  // Model state
  vec_t rows [8];
  vec_t expc [8];
  vec_t mx, mc;
  int   m_rows = 0, m_col = 0;
  bit   m_pend = 0, armed = 0;
  int   cyc = 0, acc8_cyc = -10, first_acc_cyc = 0, last_hs_cyc = 0;
  bit   chk_gap = 0, chk_dur = 0, hold_prev = 0, prev_ov = 0;
  int   lit_dc = 0;
  logic [8*N-1:0] prev_col;
  logic [2:0]     prev_idx;
  bit   tog = 0;

  always @(posedge clk) if (tog) begin #1 out_ready = ~out_ready; end

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      chk("in_ready", in_ready, !m_pend);
      chk("out_valid", out_valid, m_pend);
      chk("busy", busy, m_pend || m_rows != 0);
      if (m_pend) begin
        chk("out_idx", out_idx, m_col);
        chk("out_last", out_last, m_col == 7);
        for (int k = 0; k < 8; k++) chk("out_col lane", lane(out_col, k), expc[m_col][k]);
        if (lit_dc != 0 && m_col == 0) chk("dc literal", lane(out_col, 0), lit_dc);
      end
      if (hold_prev) begin
        chk("hold col", out_col == prev_col, 1);
        chk("hold idx", out_idx, prev_idx);
      end
      if (out_valid && !prev_ov) chk("first out latency", cyc - acc8_cyc, 1);
    end
    hold_prev = out_valid && !out_ready && !reset;
    prev_col  = out_col;
    prev_idx  = out_idx;
    prev_ov   = out_valid;
    // Advance the model to what the coming clock edge must produce.
    if (reset) begin
      m_pend = 0; m_rows = 0; m_col = 0; armed = 1;
    end else if (armed) begin
      if (!m_pend) begin
        if (in_valid) begin
          if (m_rows == 0) begin
            if (chk_gap) begin chk("b2b gap", cyc - last_hs_cyc, 1); chk_gap = 0; end
            first_acc_cyc = cyc;
          end
          for (int i = 0; i < 8; i++) mx[i] = lane(in_row, i);
          rows[m_rows] = dct8(mx);
          m_rows++;
          if (m_rows == 8) begin
            for (int c = 0; c < 8; c++) begin
              for (int r = 0; r < 8; r++) mc[r] = rows[r][c];
              expc[c] = dct8(mc);
            end
            m_pend = 1; m_rows = 0; m_col = 0; acc8_cyc = cyc;
          end
        end
      end else if (out_ready) begin
        if (m_col == 7) begin
          m_pend = 0; m_col = 0; last_hs_cyc = cyc;
          if (chk_dur) chk("block cycles", cyc - first_acc_cyc, 15);
        end else m_col++;
      end
    end
  end

  task automatic push_row(input int v, input bit keep);
    in_row = rep(v); in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        return;
      end
    end
    chk("push timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic push_block(input int v, input bit keep);
    for (int i = 0; i < 8; i++) push_row(v, keep);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin
        #1 tog = 0;
        @(posedge clk); #1;
        return;
      end
    end
    chk("done timeout", 0, 1);
  endtask

  initial begin
    vec_t t;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        real a, v;
        a = (k == 0) ? $sqrt(0.125) : 0.5;
        v = a * $cos(real'((2 * n + 1) * k) * PI / 16.0) * 4096.0;
        cf[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      end
    // Hand-computed anchors for the model itself.
    foreach (t[i]) t[i] = 10;
    t = dct8(t);
    chk("model row dc 10", t[0], 28);
    chk("model row ac 10", t[5], 0);
    foreach (t[i]) t[i] = 28;
    t = dct8(t);
    chk("model col dc 28", t[0], 79);
    foreach (t[i]) t[i] = 14;
    t = dct8(t);
    chk("model col dc 14", t[0], 39);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out_idx", out_idx, 0);
    chk("reset out_last", out_last, 0);
    @(posedge clk); #1;

    // All-zero block
    push_block(0, 0);
    wait_done();

    // Constant 10, out_ready high: 16-cycle block
    lit_dc = 79; chk_dur = 1;
    push_block(10, 0);
    wait_done();
    chk_dur = 0;

    // Constant 10 with out_ready toggling
    tog = 1;
    push_block(10, 0);
    wait_done();

    // Back-to-back blocks with in_valid held high
    push_block(10, 1);
    chk_gap = 1;
    push_row(5, 1);
    lit_dc = 39;
    for (int i = 0; i < 7; i++) push_row(5, i != 6);
    wait_done();

    // Reset after 4 rows, then a fresh block
    lit_dc = 79;
    for (int i = 0; i < 4; i++) push_row(7, 0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    push_block(10, 0);
    wait_done();

    // Reset in the column pass at index 3 with out_ready low
    push_block(10, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3'd2) break;
    end
    @(posedge clk); #1 out_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("pre-reset idx", out_idx, 3);
    @(negedge clk);
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort busy", busy, 0);
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;

    // Fresh block after abort
    push_block(10, 0);
    wait_done();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dct2d_rowcol_sched.md
Name: dct2d_rowcol_sched

Overview:
Sequencer that computes an 8x8 2-D DCT using a single shared dct1d instance in row-column fashion.
- Pass 1: accepts 8 rows, one per handshake. Each row goes through dct1d and the result is written into an internal 8x8 transpose buffer.
- Pass 2: reads the buffer column by column through the same dct1d instance and emits one column of 2-D coefficients per handshake.
- Sits between the pixel block fetcher and the approximate-adder quantiser stage.

Parameters:
N, 16, lane width in bits (signed); passed unchanged to the dct1d instance.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_row holds a valid row
in_ready  output  1  block can accept a row this cycle
in_row  input  8*N  8 signed samples; element 0 in bits [8N-1:7N], element 7 in bits [N-1:0]
out_valid  output  1  out_col holds a valid coefficient column
out_ready  input  1  downstream accepts out_col this cycle
out_col  output  8*N  coefficients Y(0..7,c) of column c; Y(0,c) in MSB lane
out_idx  output  3  column index c of out_col
out_last  output  1  high with out_valid when out_idx==7
busy  output  1  high in S_COL or when row_cnt!=0

Behaviour:
- One clock: clk. Reset is synchronous and active-high: reset.
- States: S_ROW, S_COL. Counters: row_cnt[2:0], col_cnt[2:0]. Buffer: mem[r][c], N bits each.
- Reset values: state=S_ROW, row_cnt=0, col_cnt=0, in_ready=1, out_valid=0, out_idx=0, out_last=0, busy=0. Buffer contents are not reset; they are don't-care until written.
- S_ROW:
  - in_ready=1 and out_valid=0.
  - A row is accepted when in_valid&&in_ready.
  - On acceptance, dct1d(in_row) lane k is written to mem[row_cnt][k] in the same cycle, and row_cnt increments.
  - Acceptance with row_cnt==7: row_cnt wraps to 0, col_cnt=0, next state S_COL.
- S_COL:
  - in_ready=0 and out_valid=1.
  - The dct1d input mux selects column col_cnt: {mem[0][c],...,mem[7][c]}, with mem[0][c] in the MSB lane.
  - out_col is the combinational dct1d output.
  - out_idx=col_cnt; out_last=(col_cnt==7).
  - A handshake (out_ready) increments col_cnt.
  - Handshake with col_cnt==7: next state S_ROW, col_cnt wraps to 0.
- The dct1d input mux selects in_row in S_ROW and the buffer column in S_COL. Exactly one dct1d instance exists.
- Latency: first out_valid is asserted the cycle after the 8th row is accepted. With out_ready held high, a block takes 8 row cycles plus 8 column cycles, so throughput is one block per 16 cycles minimum.
- Backpressure:
  - When out_ready=0, out_col, out_idx and out_last hold stable; the buffer is not written in S_COL.
  - A row presented while in_ready=0 is neither accepted nor dropped silently; the source must hold it.
- in_valid during S_COL is ignored. The next block's first row can be accepted in the cycle after the out_last handshake.
- Arithmetic: no width growth or saturation beyond dct1d's own N-bit wrap; buffer entries store the dct1d lane output verbatim.
- Reset mid-operation (either state) aborts the block: it returns to reset values next cycle, no partial output is emitted, and stale buffer data is never emitted before 8 new rows are accepted.
- reset overrides any simultaneous handshake.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, busy=0; after 8 all-zero rows, 8 output columns all zero, out_idx 0..7, out_last only on column 7.
- 8 rows of constant 10 (every lane 10), out_ready=1:
  - each row DCT gives lane0=28, other lanes 0.
  - column 0 out_col={79,0,0,0,0,0,0,0}; columns 1..7 all zero.
  - first out_valid exactly 1 cycle after 8th acceptance; block completes in 16 cycles.
- Same block with out_ready toggling 0/1 every cycle -> each column is held stable while out_ready=0; the 8 columns are emitted in order with no duplicates or skips; in_ready stays 0 until the out_last handshake.
- in_valid held high continuously across two back-to-back blocks (second block all 5: every 2-D output zero except column 0 lane0=39) -> the second block's first row is accepted in the cycle after the first block's out_last handshake, and the 5-valued rows yield out_col={39,0,0,0,0,0,0,0} for column 0.
- Reset asserted after 4 rows, then 8 rows of 10 -> no out_valid before the 8th new row; output matches the constant-10 case.
- Reset asserted in S_COL at out_idx=3 while out_ready=0 -> next cycle out_valid=0, in_ready=1, row_cnt=0.
